yarp_ifetch_buf: RTL and testbench
==================================

YARP_IFETCH_BUF -- requirements
Module: yarp_ifetch_buf

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning instruction buffer entries and maximum in-flight fetches; legal values are powers of 2 and at least 2.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port clk, input, 1 bit, meaning the clock.
REQ-004 SHALL have port reset_n, input, 1 bit, meaning an asynchronous active-low reset.
REQ-005 SHALL have port redirect_i, input, 1 bit, meaning flush the block and restart fetch.
REQ-006 SHALL have port redirect_pc_i, input, XLEN bits, meaning the new fetch address.
REQ-007 SHALL have port instr_mem_req_o, output, 1 bit, meaning a fetch request.
REQ-008 SHALL have port instr_mem_addr_o, output, XLEN bits, meaning the fetch address.
REQ-009 SHALL have port instr_mem_gnt_i, input, 1 bit, meaning the memory accepts the request.
REQ-010 SHALL have port mem_rvalid_i, input, 1 bit, meaning response data is valid.
REQ-011 SHALL have port mem_rd_data_i, input, XLEN bits, meaning the response instruction.
REQ-012 SHALL have port instr_valid_o, output, 1 bit, meaning instr_o and instr_pc_o are valid.
REQ-013 SHALL have port instr_ready_i, input, 1 bit, meaning the decode stage consumes the instruction.
REQ-014 SHALL have port instr_o, output, XLEN bits, meaning the fetched instruction.
REQ-015 SHALL have port instr_pc_o, output, XLEN bits, meaning the PC of instr_o.

Function
REQ-016 SHALL use a two-state FSM: IDLE, entered on reset, with request low; and FETCH, entered unconditionally on the first clock after reset and left only by reset.
REQ-017 In FETCH, SHALL assert instr_mem_req_o when outstanding + fifo_count < FIFO_DEPTH.
REQ-018 SHALL treat a request as accepted when req and gnt are both high; on acceptance fetch_pc advances by 4, wrapping modulo 2^XLEN.
REQ-019 While req is high and gnt is low, SHALL hold req and addr stable.
REQ-020 The memory SHALL return responses in order, at least 1 cycle after grant; an rvalid with zero outstanding is a protocol error and SHALL be asserted on in simulation.
REQ-021 SHALL write each non-discarded response into the FIFO, tagging it with its request PC from an in-order PC queue of FIFO_DEPTH entries.
REQ-022 SHALL drive instr_valid_o as FIFO not empty, with instr_o and instr_pc_o taken from the FIFO head; a pop occurs when instr_valid_o and instr_ready_i are both high.
REQ-023 SHALL support a simultaneous push and pop when the FIFO is full or empty, with no bubble or overflow; the FIFO SHALL never overflow because it is guaranteed by REQ-017.
REQ-024 SHALL add zero extra latency: a response arriving in cycle N is visible on instr_valid_o in cycle N+1.
REQ-025 On redirect_i, SHALL on the next edge empty the FIFO and PC queue, set fetch_pc to redirect_pc_i, and load discard_cnt with the outstanding count, including a grant occurring in the redirect cycle.
REQ-026 Responses arriving while discard_cnt > 0 SHALL decrement discard_cnt and never be pushed into the FIFO.
REQ-027 In the redirect cycle, SHALL drive instr_valid_o low.
REQ-028 If req is pending without grant at redirect, SHALL keep the old address until it is granted, then count that request as discarded; the first post-redirect request uses redirect_pc_i.
REQ-029 Redirect has priority over push and pop in the same cycle.
REQ-030 SHALL size all counters at $clog2(FIFO_DEPTH)+1 bits and never let them wrap.

Reset
REQ-031 On reset_n low, SHALL asynchronously set state to IDLE, instr_mem_req_o to 0, instr_valid_o to 0, fetch_pc to RESET_PC, and the outstanding count, discard_cnt, and FIFO pointers and count to 0.
REQ-032 SHALL hold instr_o and instr_pc_o at 0 while the FIFO is empty after reset.
REQ-033 Reset mid-transaction SHALL drop all in-flight state; the memory side is reset concurrently.

Structure
REQ-034 XLEN and an ifetch FSM state enum (IDLE, FETCH) SHALL live in yarp_pkg.
REQ-035 SHALL implement one sub-module, yarp_sync_fifo, parametrised by WIDTH and DEPTH with push/pop/full/empty/count, instantiated twice: once for data+PC, and once for the PC queue.

Verification
REQ-036 Reset release with gnt=1, rvalid 1 cycle after grant, ready=1 -> req rises 1 cycle after reset, addresses 0x0, 0x4, 0x8, and instr_pc_o follows in order with instr_o matching memory.
REQ-037 ready=0 for 10 cycles with FIFO_DEPTH=2 -> exactly 2 grants occur, req drops, and no data is lost after ready=1.
REQ-038 gnt held low 3 cycles -> addr stays 0x4 for all 3 cycles and is granted once.
REQ-039 Redirect to 0x100 with 2 requests outstanding -> the next 2 rvalids are dropped, and the first instr_pc_o after redirect is 0x100.
REQ-040 fetch_pc at 0xFFFF_FFFC -> the next address is 0x0000_0000.
REQ-041 reset_n pulsed low during an outstanding fetch -> all outputs are 0 immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/yarp_pkg.sv
// Shared definitions for the yarp fetch front end: data width and ifetch FSM states.
package yarp_pkg;

    localparam int XLEN = 32;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } ifetch_state_e;

endpackage

// File: rtl/yarp_sync_fifo.sv
// Synchronous FIFO with flush; a push into a full FIFO is accepted only alongside a pop.
module yarp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // An empty FIFO presents zero rather than stale storage.
    assign rd_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/yarp_ifetch_buf.sv
// Instruction fetch buffer: issues in-order fetches, tags responses with their PC,
// queues them for decode and discards in-flight responses after a redirect.
module yarp_ifetch_buf
    import yarp_pkg::*;
#(
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_mem_req_o,
    output logic [XLEN-1:0] instr_mem_addr_o,
    input  logic            instr_mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rd_data_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int CW1 = CW + 1;

    ifetch_state_e     state;
    logic [XLEN-1:0]   fetch_pc;
    logic [XLEN-1:0]   hold_pc;
    logic              hold_pending;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     discard_cnt;
    logic [CW-1:0]     discard_nxt;
    logic [CW-1:0]     fifo_count;
    logic [CW-1:0]     pcq_count;
    logic [CW:0]       inflight;
    logic              accept;
    logic              rsp_dec;
    logic              keep_rsp;
    logic              drop_rsp;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              pcq_full;
    logic              pcq_empty;
    logic              pcq_push;
    logic              pcq_pop;
    logic [XLEN-1:0]   pcq_head;
    logic [2*XLEN-1:0] fifo_head;

    // Handshakes: memory request transfers when req && gnt, and req/addr hold until then;
    // decode transfer happens when instr_valid_o && instr_ready_i on the same edge.
    assign inflight         = {1'b0, outstanding} + {1'b0, fifo_count};
    assign instr_mem_req_o  = (state == FETCH) && (inflight < CW1'(FIFO_DEPTH));
    assign instr_mem_addr_o = hold_pending ? hold_pc : fetch_pc;
    assign accept           = instr_mem_req_o && instr_mem_gnt_i;
    assign rsp_dec          = mem_rvalid_i && (outstanding != '0);
    assign drop_rsp         = mem_rvalid_i && (discard_cnt != '0);
    assign keep_rsp         = mem_rvalid_i && (discard_cnt == '0);

    always_comb begin
        outstanding_nxt = outstanding;
        case ({accept, rsp_dec})
            2'b10:   outstanding_nxt = outstanding + CW'(1);
            2'b01:   outstanding_nxt = outstanding - CW'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // A request held across a redirect is still issued, but its response is unwanted.
    always_comb begin
        discard_nxt = discard_cnt;
        case ({accept && hold_pending, drop_rsp})
            2'b10:   discard_nxt = discard_cnt + CW'(1);
            2'b01:   discard_nxt = discard_cnt - CW'(1);
            default: discard_nxt = discard_cnt;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            hold_pc      <= '0;
            hold_pending <= 1'b0;
            outstanding  <= '0;
            discard_cnt  <= '0;
        end else begin
            state       <= FETCH;
            outstanding <= outstanding_nxt;
            if (redirect_i) begin
                fetch_pc     <= redirect_pc_i;
                discard_cnt  <= outstanding_nxt;
                hold_pending <= instr_mem_req_o && !instr_mem_gnt_i;
                hold_pc      <= instr_mem_addr_o;
            end else begin
                discard_cnt <= discard_nxt;
                if (accept && !hold_pending) fetch_pc <= fetch_pc + XLEN'(4);
                if (accept) hold_pending <= 1'b0;
            end
        end
    end

    assign pcq_push  = accept && !hold_pending && !redirect_i;
    assign pcq_pop   = keep_rsp && !redirect_i;
    assign fifo_push = keep_rsp && !redirect_i;
    assign fifo_pop  = instr_valid_o && instr_ready_i;

    yarp_sync_fifo #(.WIDTH(XLEN), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_i),
        .push    (pcq_push),
        .wr_data (instr_mem_addr_o),
        .pop     (pcq_pop),
        .rd_data (pcq_head),
        .full    (pcq_full),
        .empty   (pcq_empty),
        .count   (pcq_count)
    );

    yarp_sync_fifo #(.WIDTH(2*XLEN), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (redirect_i),
        .push    (fifo_push),
        .wr_data ({pcq_head, mem_rd_data_i}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign instr_valid_o = !fifo_empty && !redirect_i;
    assign instr_pc_o    = fifo_head[2*XLEN-1:XLEN];
    assign instr_o       = fifo_head[XLEN-1:0];

    a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_rvalid_i && outstanding == '0));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(pcq_push && pcq_full) && !(pcq_pop && pcq_empty));
    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(fifo_push && fifo_full && !fifo_pop));
    // Every outstanding fetch is either tagged in the PC queue or marked for discard.
    a_inflight_tracked: assert property (@(posedge clk) disable iff (!reset_n)
        (pcq_count + discard_cnt) == outstanding);

endmodule

// File: tb/tb_yarp_ifetch_buf.sv
// Directed bench for yarp_ifetch_buf with an in-order memory model and a PC/data scoreboard.
module tb_yarp_ifetch_buf;
    import yarp_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        valid;
    logic        ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int          vectors = 0;
    int          miscompares = 0;
    int          n_accept = 0;
    int          pops = 0;
    int          base;
    int          budget;
    logic        rsp_en;
    logic        drop_accept;
    logic [31:0] held_addr;
    logic [31:0] exp_fetch_pc;
    logic [31:0] first_pop_pc;
    logic [31:0] mem_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] acc_q[$];

    yarp_ifetch_buf #(.FIFO_DEPTH(2), .RESET_PC(RST_PC)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .instr_mem_req_o  (req),
        .instr_mem_addr_o (addr),
        .instr_mem_gnt_i  (gnt),
        .mem_rvalid_i     (rvalid),
        .mem_rd_data_i    (rdata),
        .instr_valid_o    (valid),
        .instr_ready_i    (ready),
        .instr_o          (instr),
        .instr_pc_o       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        if (acc_q.size() > i) return acc_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic observe();
        logic [63:0] e;
        if (req && gnt) begin
            n_accept++;
            acc_q.push_back(addr);
            mem_q.push_back(addr);
            if (drop_accept) begin
                drop_accept = 1'b0;
                check("held_grant_addr", addr, held_addr);
            end else begin
                check("fetch_addr", addr, exp_fetch_pc);
                exp_q.push_back({exp_fetch_pc, mem_data(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
        end
        if (redirect) begin
            check("valid_in_redirect", 32'(valid), 32'h0);
            exp_q.delete();
            exp_fetch_pc = redirect_pc;
        end
        if (valid && ready) begin
            if (pops == 0) first_pop_pc = instr_pc;
            pops++;
            if (exp_q.size() == 0) begin
                check("unexpected_instr", 32'(valid), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e[63:32]);
                check("instr_data", instr, e[31:0]);
            end
        end
    endtask

    task automatic cycle();
        if (rsp_en && mem_q.size() > 0) begin
            rvalid = 1'b1;
            rdata  = mem_data(mem_q.pop_front());
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
        end
        #2;
        observe();
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        cycle();
        next();
    endtask

    task automatic reset_pulse();
        reset_n  = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        redirect = 1'b0;
        #1;
        check("rst_req", 32'(req), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        mem_q.delete();
        exp_q.delete();
        exp_fetch_pc = RST_PC;
        drop_accept  = 1'b0;
        next();
        reset_n = 1'b1;
        cycle();
        check("idle_req_low", 32'(req), 32'h0);
        next();
    endtask

    task automatic drain();
        int left = 40;
        gnt    = 1'b0;
        ready  = 1'b1;
        rsp_en = 1'b1;
        while ((mem_q.size() != 0 || exp_q.size() != 0 || valid) && left > 0) begin
            step();
            left--;
        end
        check("drain_left", exp_q.size(), 32'h0);
    endtask

    initial begin
        reset_n     = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        gnt         = 1'b0;
        ready       = 1'b0;
        rvalid      = 1'b0;
        rdata       = '0;
        rsp_en      = 1'b0;
        drop_accept = 1'b0;
        held_addr   = '0;
        exp_fetch_pc = RST_PC;
        first_pop_pc = '0;
        next();

        // Reset state, then streaming fetch from RESET_PC.
        gnt = 1'b1; ready = 1'b1; rsp_en = 1'b1;
        reset_pulse();
        acc_q.delete();
        cycle();
        check("req_rise", 32'(req), 32'h1);
        check("first_addr", addr, RST_PC);
        next();
        cycle();
        check("valid_before_rsp", 32'(valid), 32'h0);
        next();
        cycle();
        check("valid_n_plus_1", 32'(valid), 32'h1);
        check("head_pc", instr_pc, 32'h0);
        next();
        repeat (6) step();
        check("seq_addr0", acc_at(0), 32'h0);
        check("seq_addr1", acc_at(1), 32'h4);
        check("seq_addr2", acc_at(2), 32'h8);

        // Reset while fetches are in flight, then decode stalled for 10 cycles.
        rsp_en = 1'b0;
        step();
        step();
        gnt = 1'b1; ready = 1'b0; rsp_en = 1'b1;
        reset_pulse();
        base = n_accept;
        repeat (10) step();
        check("stall_grants", n_accept - base, 32'd2);
        cycle();
        check("stall_req_low", 32'(req), 32'h0);
        check("stall_valid", 32'(valid), 32'h1);
        next();
        drain();

        // Grant withheld for 3 cycles on the second request.
        gnt = 1'b1; ready = 1'b1; rsp_en = 1'b1;
        reset_pulse();
        step();
        gnt = 1'b0;
        base = n_accept;
        repeat (3) begin
            cycle();
            check("nogrant_req", 32'(req), 32'h1);
            check("nogrant_addr", addr, 32'h4);
            next();
        end
        gnt = 1'b1;
        step();
        check("nogrant_one_grant", n_accept - base, 32'd1);
        drain();

        // Redirect with two fetches outstanding.
        gnt = 1'b1; rsp_en = 1'b0; ready = 1'b1;
        step();
        step();
        cycle();
        check("full_req_low", 32'(req), 32'h0);
        next();
        gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect = 1'b0; gnt = 1'b1; rsp_en = 1'b1;
        pops = 0;
        first_pop_pc = 32'hDEAD_DEAD;
        budget = 20;
        while (pops == 0 && budget > 0) begin
            step();
            budget--;
        end
        check("first_pc_after_redirect", first_pop_pc, 32'h0000_0100);
        drain();

        // Redirect while a request waits for grant: old address kept, then discarded.
        cycle();
        check("pending_req", 32'(req), 32'h1);
        next();
        held_addr   = exp_fetch_pc;
        drop_accept = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        step();
        redirect = 1'b0;
        cycle();
        check("held_addr_kept", addr, held_addr);
        next();
        gnt = 1'b1;
        step();
        check("held_granted", 32'(drop_accept), 32'h0);
        pops = 0;
        first_pop_pc = 32'hDEAD_DEAD;
        repeat (5) step();
        check("first_pc_after_held", first_pop_pc, 32'h0000_0200);
        drain();

        // Fetch address wraps past the top of the address space.
        gnt = 1'b1; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        acc_q.delete();
        repeat (6) step();
        check("wrap_addr0", acc_at(0), 32'hFFFF_FFFC);
        check("wrap_addr1", acc_at(1), 32'h0000_0000);
        drain();

        cycle();
        check("final_valid", 32'(valid), 32'h0);
        next();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
